// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-phase traffic controller: controller states
// and the default interval/sizing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2,
    ST_FLASH   = 2'd3
  } state_e;

  localparam int DEF_NUM_PHASES   = 4;
  localparam int DEF_TIMER_W      = 8;
  localparam int DEF_GREEN_TIME   = 15;
  localparam int DEF_YELLOW_TIME  = 5;
  localparam int DEF_ALL_RED_TIME = 2;
  localparam int DEF_CLK_DIV      = 1;

endpackage

// File: rtl/multi_phase_traffic_ctrl_if.sv
// Demand/lamp bundle between the intersection side (master) and the
// traffic controller (slave).
interface multi_phase_traffic_ctrl_if
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int TIMER_W    = DEF_TIMER_W
) ();
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic [NUM_PHASES-1:0] veh_req;
  logic                  flash;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] red;
  logic [PW-1:0]         phase;
  logic [TIMER_W-1:0]    timer;
  logic [NUM_PHASES-1:0] pending;

  modport master (
    output veh_req, flash,
    input  green, yellow, red, phase, timer, pending
  );

  modport slave (
    input  veh_req, flash,
    output green, yellow, red, phase, timer, pending
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into a one-clock tick pulse every CLK_DIV clocks; the first tick
// after reset release lands CLK_DIV clocks later.
module tick_prescaler #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = (count_q == CW'(CLK_DIV - 1));
    count_d = tick ? {CW{1'b0}} : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-phase traffic signal controller: demand-driven phase rotation resting
// in phase 0, fixed-length green/yellow/all-red intervals and a flash mode.
module multi_phase_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES   = DEF_NUM_PHASES,
  parameter int TIMER_W      = DEF_TIMER_W,
  parameter int GREEN_TIME   = DEF_GREEN_TIME,
  parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
  parameter int CLK_DIV      = DEF_CLK_DIV
) (
  input logic                       clk,
  input logic                       reset,
  multi_phase_traffic_ctrl_if.slave bus
);
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [NUM_PHASES-1:0] pending_q, pending_d;
  logic                  lit_q, lit_d;
  logic                  recover_q, recover_d;
  logic [PW-1:0]         next_phase_s;
  logic                  tick_s;
  logic [NUM_PHASES-1:0] green_s, yellow_s, red_s;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  // Descending scan so the lowest pending index above the current phase wins.
  always_comb begin
    next_phase_s = {PW{1'b0}};
    for (int i = NUM_PHASES - 1; i >= 1; i--) begin
      next_phase_s = ((i > int'(phase_q)) && pending_q[i]) ? PW'(i) : next_phase_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    timer_d   = timer_q;
    lit_d     = lit_q;
    recover_d = recover_q;
    pending_d = pending_q;
    for (int i = 1; i < NUM_PHASES; i++) begin
      pending_d[i] = pending_q[i] |
                     (bus.veh_req[i] & ~((state_q == ST_GREEN) && (int'(phase_q) == i)));
    end
    pending_d[0] = 1'b0;

    if (bus.flash && (state_q != ST_FLASH)) begin
      state_d = ST_FLASH;
      phase_d = {PW{1'b0}};
      timer_d = {TIMER_W{1'b0}};
      lit_d   = 1'b1;
    end else if (state_q == ST_FLASH) begin
      if (!bus.flash) begin
        // Leaving flash always clears the box and then serves main first.
        state_d   = ST_ALL_RED;
        timer_d   = TIMER_W'(ALL_RED_TIME);
        recover_d = 1'b1;
      end else if (tick_s) begin
        lit_d = ~lit_q;
      end else begin
        lit_d = lit_q;
      end
    end else if (tick_s) begin
      if (timer_q > TIMER_W'(1)) begin
        timer_d = timer_q - TIMER_W'(1);
      end else begin
        case (state_q)
          ST_GREEN: begin
            if ((phase_q == {PW{1'b0}}) && (pending_q == {NUM_PHASES{1'b0}})) begin
              timer_d = TIMER_W'(GREEN_TIME);
            end else begin
              state_d = ST_YELLOW;
              timer_d = TIMER_W'(YELLOW_TIME);
            end
          end
          ST_YELLOW: begin
            state_d = ST_ALL_RED;
            timer_d = TIMER_W'(ALL_RED_TIME);
          end
          ST_ALL_RED: begin
            state_d   = ST_GREEN;
            timer_d   = TIMER_W'(GREEN_TIME);
            recover_d = 1'b0;
            if (recover_q) begin
              phase_d = {PW{1'b0}};
            end else begin
              phase_d                 = next_phase_s;
              pending_d[next_phase_s] = 1'b0;
            end
          end
          default: begin
            state_d = ST_GREEN;
            phase_d = {PW{1'b0}};
            timer_d = TIMER_W'(GREEN_TIME);
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_GREEN;
      phase_q   <= {PW{1'b0}};
      timer_q   <= TIMER_W'(GREEN_TIME);
      pending_q <= {NUM_PHASES{1'b0}};
      lit_q     <= 1'b1;
      recover_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      lit_q     <= lit_d;
      recover_q <= recover_d;
    end
  end

  // Lamps decode straight from state so reset shows immediately.
  always_comb begin
    green_s  = {NUM_PHASES{1'b0}};
    yellow_s = {NUM_PHASES{1'b0}};
    red_s    = {NUM_PHASES{1'b1}};
    case (state_q)
      ST_GREEN: begin
        green_s[phase_q] = 1'b1;
        red_s[phase_q]   = 1'b0;
      end
      ST_YELLOW: begin
        yellow_s[phase_q] = 1'b1;
        red_s[phase_q]    = 1'b0;
      end
      ST_ALL_RED: red_s = {NUM_PHASES{1'b1}};
      ST_FLASH:   red_s = {NUM_PHASES{lit_q}};
      default:    red_s = {NUM_PHASES{1'b1}};
    endcase
  end

  assign bus.green   = green_s;
  assign bus.yellow  = yellow_s;
  assign bus.red     = red_s;
  assign bus.phase   = phase_q;
  assign bus.timer   = timer_q;
  assign bus.pending = pending_q;
endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Bench for multi_phase_traffic_ctrl: directed scenarios plus randomized
// demand/flash traffic checked against an interval-based reference model.
module tb_multi_phase_traffic_ctrl;
  localparam int NP = 4, TW = 8, G_T = 5, Y_T = 2, AR_T = 1, DIV_A = 1, DIV_B = 4;
  localparam int MD_GREEN = 0, MD_YELLOW = 1, MD_ALLRED = 2, MD_FLASH = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multi_phase_traffic_ctrl_if #(.NUM_PHASES(NP), .TIMER_W(TW)) bus_a ();
  multi_phase_traffic_ctrl_if #(.NUM_PHASES(NP), .TIMER_W(TW)) bus_b ();

  multi_phase_traffic_ctrl #(.NUM_PHASES(NP), .TIMER_W(TW), .GREEN_TIME(G_T),
    .YELLOW_TIME(Y_T), .ALL_RED_TIME(AR_T), .CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));

  multi_phase_traffic_ctrl #(.NUM_PHASES(NP), .TIMER_W(TW), .GREEN_TIME(G_T),
    .YELLOW_TIME(Y_T), .ALL_RED_TIME(AR_T), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: interval kind, ticks elapsed and interval length.
  int         m_mode, m_phase, m_len, m_elapsed, m_presc;
  logic [3:0] m_pend;
  logic       m_lit, m_recover;

  function automatic int scan_next(input int cur, input logic [3:0] pend);
    int j;
    for (int k = 1; k < NP; k++) begin
      j = (cur + k) % NP;
      if (j == 0) return 0;
      if (pend[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = MD_GREEN; m_phase = 0; m_len = G_T; m_elapsed = 0; m_presc = 0;
    m_pend = 4'b0000; m_lit = 1'b1; m_recover = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] vr, input logic fl);
    logic [3:0] np;
    logic       tk;
    int         nx;
    tk = (m_presc == DIV_A - 1);
    m_presc = tk ? 0 : m_presc + 1;
    np = m_pend;
    for (int i = 1; i < NP; i++)
      if (vr[i] && !(m_mode == MD_GREEN && m_phase == i)) np[i] = 1'b1;
    if (fl && m_mode != MD_FLASH) begin
      m_mode = MD_FLASH; m_phase = 0; m_lit = 1'b1;
    end else if (m_mode == MD_FLASH) begin
      if (!fl) begin
        m_mode = MD_ALLRED; m_len = AR_T; m_elapsed = 0; m_recover = 1'b1;
      end else if (tk) begin
        m_lit = ~m_lit;
      end
    end else if (tk) begin
      m_elapsed++;
      if (m_elapsed == m_len) begin
        m_elapsed = 0;
        if (m_mode == MD_GREEN) begin
          if (!(m_phase == 0 && m_pend == 4'b0000)) begin
            m_mode = MD_YELLOW; m_len = Y_T;
          end
        end else if (m_mode == MD_YELLOW) begin
          m_mode = MD_ALLRED; m_len = AR_T;
        end else begin
          nx = m_recover ? 0 : scan_next(m_phase, m_pend);
          m_mode = MD_GREEN; m_phase = nx; m_len = G_T; np[nx] = 1'b0; m_recover = 1'b0;
        end
      end
    end
    m_pend = np;
  endtask

  task automatic step(input logic [3:0] vr, input logic fl);
    bus_a.veh_req = vr;
    bus_a.flash   = fl;
    @(posedge clk);
    model_edge(vr, fl);
    #1;
  endtask

  task automatic do_reset();
    bus_a.veh_req = 4'b0000; bus_a.flash = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus_a.veh_req = 4'b0000; bus_a.flash = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (bus_a.green !== 4'b0001) begin failures++; $display("FAIL reset_green got=%b exp=0001", bus_a.green); end
    if (bus_a.yellow !== 4'b0000) begin failures++; $display("FAIL reset_yellow got=%b exp=0000", bus_a.yellow); end
    if (bus_a.red !== 4'b1110) begin failures++; $display("FAIL reset_red got=%b exp=1110", bus_a.red); end
    if (bus_a.phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus_a.phase); end
    if (bus_a.timer !== 8'd5) begin failures++; $display("FAIL reset_timer got=%0d exp=5", bus_a.timer); end
    if (bus_a.pending !== 4'b0000) begin failures++; $display("FAIL reset_pending got=%b exp=0000", bus_a.pending); end
    if (bus_b.timer !== 8'd5) begin failures++; $display("FAIL reset_timer_b got=%0d exp=5", bus_b.timer); end
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_rest_in_main();
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      step(4'b0001, 1'b0);
      checks += 3;
      if (bus_a.timer !== TW'(5 - (n % 5))) begin failures++; $display("FAIL rest_timer n=%0d got=%0d exp=%0d", n, bus_a.timer, 5 - (n % 5)); end
      if (bus_a.green !== 4'b0001) begin failures++; $display("FAIL rest_green n=%0d got=%b exp=0001", n, bus_a.green); end
      if (bus_a.yellow !== 4'b0000 || bus_a.pending !== 4'b0000) begin
        failures++; $display("FAIL rest_yellow_pend n=%0d yellow=%b pending=%b exp=0000/0000", n, bus_a.yellow, bus_a.pending);
      end
    end
  endtask

  task automatic test_single_request();
    logic [3:0] eg, ey;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      step((n == 3) ? 4'b0100 : 4'b0000, 1'b0);
      eg = 4'b0000; ey = 4'b0000;
      if (n <= 4) eg = 4'b0001;
      else if (n <= 6) ey = 4'b0001;
      else if (n == 7) eg = 4'b0000;
      else if (n <= 12) eg = 4'b0100;
      else if (n <= 14) ey = 4'b0100;
      else if (n >= 16) eg = 4'b0001;
      checks += 2;
      if (bus_a.green !== eg) begin failures++; $display("FAIL single_green n=%0d got=%b exp=%b", n, bus_a.green, eg); end
      if (bus_a.yellow !== ey) begin failures++; $display("FAIL single_yellow n=%0d got=%b exp=%b", n, bus_a.yellow, ey); end
      if (n == 7 || n == 15) begin
        checks++;
        if (bus_a.red !== 4'b1111) begin failures++; $display("FAIL single_allred n=%0d got=%b exp=1111", n, bus_a.red); end
      end
      if (n == 8) begin
        checks += 2;
        if (bus_a.timer !== 8'd5) begin failures++; $display("FAIL single_g2_timer got=%0d exp=5", bus_a.timer); end
        if (bus_a.pending !== 4'b0000) begin failures++; $display("FAIL single_g2_pend got=%b exp=0000", bus_a.pending); end
      end
    end
  endtask

  task automatic test_two_requests();
    int q[$];
    int last, gi;
    int exp_order[4];
    exp_order = '{0, 1, 3, 0};
    last = -1;
    do_reset();
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) step((n == 1) ? 4'b1010 : ((n >= 17 && n <= 19) ? 4'b1000 : 4'b0000), 1'b0);
      gi = -1;
      for (int i = 0; i < NP; i++) if (bus_a.green[i]) gi = i;
      if (gi >= 0 && gi != last) begin q.push_back(gi); last = gi; end
      if (n == 20) begin
        checks++;
        if (bus_a.pending !== 4'b0000) begin failures++; $display("FAIL two_req_g3_relatch got=%b exp=0000", bus_a.pending); end
      end
    end
    checks++;
    if (q.size() != 4) begin
      failures++; $display("FAIL two_req_order_len got=%0d exp=4", q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (q[k] != exp_order[k]) begin failures++; $display("FAIL two_req_order k=%0d got=%0d exp=%0d", k, q[k], exp_order[k]); end
      end
    end
  endtask

  task automatic test_flash();
    logic [3:0] er;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      step((n == 1) ? 4'b1010 : 4'b0000, (n >= 14 && n <= 18));
      if (n == 13) begin
        checks++;
        if (bus_a.yellow !== 4'b0010) begin failures++; $display("FAIL flash_pre_yellow got=%b exp=0010", bus_a.yellow); end
      end
      if (n >= 14 && n <= 18) begin
        er = ((n - 14) % 2 == 0) ? 4'b1111 : 4'b0000;
        checks += 4;
        if (bus_a.red !== er) begin failures++; $display("FAIL flash_red n=%0d got=%b exp=%b", n, bus_a.red, er); end
        if ((bus_a.green | bus_a.yellow) !== 4'b0000) begin failures++; $display("FAIL flash_gy n=%0d got=%b/%b exp=0", n, bus_a.green, bus_a.yellow); end
        if (bus_a.timer !== 8'd0 || bus_a.phase !== 2'd0) begin failures++; $display("FAIL flash_tp n=%0d timer=%0d phase=%0d exp=0/0", n, bus_a.timer, bus_a.phase); end
        if (bus_a.pending !== 4'b1000) begin failures++; $display("FAIL flash_pend n=%0d got=%b exp=1000", n, bus_a.pending); end
      end
      if (n == 19) begin
        checks++;
        if (bus_a.red !== 4'b1111 || bus_a.timer !== 8'd1) begin failures++; $display("FAIL flash_exit_allred red=%b timer=%0d exp=1111/1", bus_a.red, bus_a.timer); end
      end
      if (n == 20) begin
        checks++;
        if (bus_a.green !== 4'b0001 || bus_a.timer !== 8'd5 || bus_a.pending !== 4'b1000) begin
          failures++; $display("FAIL flash_recover green=%b timer=%0d pending=%b exp=0001/5/1000", bus_a.green, bus_a.timer, bus_a.pending);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0010, 1'b0);
    for (int k = 0; k < 20 && m_mode != MD_ALLRED; k++) step(4'b0000, 1'b0);
    checks++;
    if (m_mode != MD_ALLRED || bus_a.red !== 4'b1111) begin
      failures++; $display("FAIL async_setup_allred red=%b exp=1111", bus_a.red);
    end
    #2;
    reset = 1'b0;
    #1;
    checks += 4;
    if (bus_a.green !== 4'b0001 || bus_a.red !== 4'b1110) begin failures++; $display("FAIL async_lamps green=%b red=%b exp=0001/1110", bus_a.green, bus_a.red); end
    if (bus_a.yellow !== 4'b0000) begin failures++; $display("FAIL async_yellow got=%b exp=0000", bus_a.yellow); end
    if (bus_a.timer !== 8'd5 || bus_a.phase !== 2'd0) begin failures++; $display("FAIL async_tp timer=%0d phase=%0d exp=5/0", bus_a.timer, bus_a.phase); end
    if (bus_a.pending !== 4'b0000) begin failures++; $display("FAIL async_pending got=%b exp=0000", bus_a.pending); end
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] vr, eg, ey, er;
    logic       fl;
    int         fl_left;
    fl_left = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NP; i++) vr[i] = ($urandom_range(0, 11) == 0);
      if (fl_left > 0) begin
        fl_left--; fl = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        fl_left = $urandom_range(0, 7); fl = 1'b1;
      end else begin
        fl = 1'b0;
      end
      step(vr, fl);
      eg = (m_mode == MD_GREEN) ? (4'b0001 << m_phase) : 4'b0000;
      ey = (m_mode == MD_YELLOW) ? (4'b0001 << m_phase) : 4'b0000;
      if (m_mode == MD_FLASH) er = {4{m_lit}};
      else if (m_mode == MD_ALLRED) er = 4'b1111;
      else er = ~(4'b0001 << m_phase);
      checks += 6;
      if (bus_a.green !== eg) begin failures++; $display("FAIL rand_green n=%0d got=%b exp=%b", n, bus_a.green, eg); end
      if (bus_a.yellow !== ey) begin failures++; $display("FAIL rand_yellow n=%0d got=%b exp=%b", n, bus_a.yellow, ey); end
      if (bus_a.red !== er) begin failures++; $display("FAIL rand_red n=%0d got=%b exp=%b", n, bus_a.red, er); end
      if (bus_a.phase !== 2'(m_phase)) begin failures++; $display("FAIL rand_phase n=%0d got=%0d exp=%0d", n, bus_a.phase, m_phase); end
      if (bus_a.timer !== TW'((m_mode == MD_FLASH) ? 0 : m_len - m_elapsed)) begin
        failures++; $display("FAIL rand_timer n=%0d got=%0d exp=%0d", n, bus_a.timer, (m_mode == MD_FLASH) ? 0 : m_len - m_elapsed);
      end
      if (bus_a.pending !== m_pend) begin failures++; $display("FAIL rand_pending n=%0d got=%b exp=%b", n, bus_a.pending, m_pend); end
    end
  endtask

  task automatic test_clk_div();
    do_reset();
    checks++;
    if (bus_b.timer !== 8'd5) begin failures++; $display("FAIL div_timer0 got=%0d exp=5", bus_b.timer); end
    for (int n = 1; n <= 40; n++) begin
      step(4'b0000, 1'b0);
      checks += 2;
      if (bus_b.timer !== TW'(5 - ((n / DIV_B) % 5))) begin
        failures++; $display("FAIL div_timer n=%0d got=%0d exp=%0d", n, bus_b.timer, 5 - ((n / DIV_B) % 5));
      end
      if (bus_b.green !== 4'b0001 || bus_b.yellow !== 4'b0000) begin
        failures++; $display("FAIL div_lamps n=%0d green=%b yellow=%b exp=0001/0000", n, bus_b.green, bus_b.yellow);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus_a.veh_req = 4'b0000; bus_a.flash = 1'b0;
    bus_b.veh_req = 4'b0000; bus_b.flash = 1'b0;
    model_reset();
    test_reset();
    test_rest_in_main();
    test_single_request();
    test_two_requests();
    test_flash();
    test_async_reset();
    test_random();
    test_clk_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
